// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg : shared types and constants for the pipeline stall control
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef logic [2:0] reg_idx_t;

  localparam logic [15:0] NOP_INSTR        = 16'h0800;
  localparam int unsigned DEFAULT_MAX_WAIT = 64;

endpackage

`default_nettype wire

// File: rtl/hazard_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_if : hazard inputs and latch controls of the stall unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import pipe_ctrl_pkg::*;

  reg_idx_t         id_rs;
  reg_idx_t         id_rt;
  logic             id_ReadingRs;
  logic             id_ReadingRt;
  reg_idx_t         ex_dst;
  logic             ex_RegWrite;
  logic             ex_MemToReg;
  logic             ex_BranchTaken;
  logic             dmem_Stall;
  logic             dmem_Done;
  logic             imem_Stall;
  logic             pc_en;
  logic             ifid_en;
  logic             flush_ifid;
  logic             stall;
  logic             stallMemStall;
  logic [CNT_W-1:0] stall_cycles;
  logic             mem_timeout;

  modport master (
    input  id_rs, id_rt, id_ReadingRs, id_ReadingRt,
    input  ex_dst, ex_RegWrite, ex_MemToReg, ex_BranchTaken,
    input  dmem_Stall, dmem_Done, imem_Stall,
    output pc_en, ifid_en, flush_ifid, stall, stallMemStall,
    output stall_cycles, mem_timeout
  );

  modport slave (
    output id_rs, id_rt, id_ReadingRs, id_ReadingRt,
    output ex_dst, ex_RegWrite, ex_MemToReg, ex_BranchTaken,
    output dmem_Stall, dmem_Done, imem_Stall,
    input  pc_en, ifid_en, flush_ifid, stall, stallMemStall,
    input  stall_cycles, mem_timeout
  );

endinterface

`default_nettype wire

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect : combinational load-use comparator between ID and EX
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  reg_idx_t id_rs,
  input  reg_idx_t id_rt,
  input  logic     id_ReadingRs,
  input  logic     id_ReadingRt,
  input  reg_idx_t ex_dst,
  input  logic     ex_RegWrite,
  input  logic     ex_MemToReg,
  output logic     load_use
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = id_ReadingRs & (id_rs == ex_dst);
  assign w_rt_hit = id_ReadingRt & (id_rt == ex_dst);
  assign load_use = ex_MemToReg & ex_RegWrite & (w_rs_hit | w_rt_hit);

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl : pipeline stall/flush controller with memory-wait FSM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_ctrl_if.master bus
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

  logic w_load_use;
  logic w_mem_hold;
  logic w_pc_en;
  logic w_ifid_en;
  logic w_flush_ifid;
  logic w_stall;
  logic w_stall_mem;

  hazard_detect u_hazard_detect (
    .id_rs        (bus.id_rs),
    .id_rt        (bus.id_rt),
    .id_ReadingRs (bus.id_ReadingRs),
    .id_ReadingRt (bus.id_ReadingRt),
    .ex_dst       (bus.ex_dst),
    .ex_RegWrite  (bus.ex_RegWrite),
    .ex_MemToReg  (bus.ex_MemToReg),
    .load_use     (w_load_use)
  );

  // The entry cycle already holds, and the dmem_Done cycle already releases.
  assign w_mem_hold = ~bus.dmem_Done & ((state_q == MEM_WAIT) | bus.dmem_Stall);

  always_comb begin
    state_d       = w_mem_hold ? MEM_WAIT : RUN;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;

    if (state_q == RUN) begin
      if (w_mem_hold) begin
        wait_cnt_d = '0;
      end
    end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    if (wait_cnt_d == WAIT_W'(MAX_WAIT)) begin
      mem_timeout_d = 1'b1;
    end
  end

  // Everything stays low while reset is held so the PC cannot advance.
  always_comb begin
    w_pc_en      = 1'b0;
    w_ifid_en    = 1'b0;
    w_flush_ifid = 1'b0;
    w_stall      = 1'b0;
    w_stall_mem  = 1'b0;

    if (rst) begin
      if (w_mem_hold) begin
        w_stall_mem = 1'b1;
      end else if (bus.ex_BranchTaken) begin
        w_flush_ifid = 1'b1;
        w_stall      = 1'b1;
        w_pc_en      = 1'b1;
        w_ifid_en    = 1'b1;
      end else if (w_load_use) begin
        w_stall = 1'b1;
      end else if (bus.imem_Stall) begin
        w_flush_ifid = 1'b1;
      end else begin
        w_pc_en   = 1'b1;
        w_ifid_en = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!w_pc_en && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.pc_en         = w_pc_en;
  assign bus.ifid_en       = w_ifid_en;
  assign bus.flush_ifid    = w_flush_ifid;
  assign bus.stall         = w_stall;
  assign bus.stallMemStall = w_stall_mem;
  assign bus.stall_cycles  = stall_cycles_q;
  assign bus.mem_timeout   = mem_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl : vector table plus multi-cycle sequences, queue scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_stall_ctrl;

  typedef struct packed {
    logic [2:0] rs;
    logic [2:0] rt;
    logic       rrs;
    logic       rrt;
    logic [2:0] dst;
    logic       rw;
    logic       m2r;
    logic       br;
    logic       ds;
    logic       dd;
    logic       is;
  } stim_t;

  // pc_en, ifid_en, flush_ifid, stall, stallMemStall
  typedef logic [4:0] outs_t;

  typedef struct {
    stim_t s;
    outs_t e;
  } vec_t;

  typedef struct {
    outs_t      o;
    logic [3:0] cnt;
    logic       to;
    int         tag;
  } exp_t;

  localparam outs_t NRM = 5'b11000;
  localparam outs_t LU  = 5'b00010;
  localparam outs_t BR  = 5'b11110;
  localparam outs_t IM  = 5'b00100;
  localparam outs_t MW  = 5'b00001;
  localparam int    NV  = 14;

  logic clk;
  logic rst_n;

  hazard_stall_ctrl_if #(.CNT_W(4)) bus ();

  hazard_stall_ctrl #(
    .MAX_WAIT (8),
    .CNT_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total;
  int         bad;
  logic [3:0] exp_cnt;
  logic       exp_to;
  exp_t       sb[$];
  vec_t       tbl[NV];

  function automatic stim_t mk_s(input logic [2:0] rs, input logic [2:0] rt,
                                 input logic rrs, input logic rrt,
                                 input logic [2:0] dst, input logic rw,
                                 input logic m2r, input logic br,
                                 input logic ds, input logic dd, input logic is);
    stim_t s;
    s.rs = rs; s.rt = rt; s.rrs = rrs; s.rrt = rrt; s.dst = dst;
    s.rw = rw; s.m2r = m2r; s.br = br; s.ds = ds; s.dd = dd; s.is = is;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.id_rs          = s.rs;
    bus.id_rt          = s.rt;
    bus.id_ReadingRs   = s.rrs;
    bus.id_ReadingRt   = s.rrt;
    bus.ex_dst         = s.dst;
    bus.ex_RegWrite    = s.rw;
    bus.ex_MemToReg    = s.m2r;
    bus.ex_BranchTaken = s.br;
    bus.dmem_Stall     = s.ds;
    bus.dmem_Done      = s.dd;
    bus.imem_Stall     = s.is;
  endtask

  task automatic cmp(input string name, input int tag,
                     input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s tag=%0d got=%0h want=%0h", name, tag, got, want);
    end
  endtask

  function automatic outs_t dut_outs();
    return {bus.pc_en, bus.ifid_en, bus.flush_ifid, bus.stall, bus.stallMemStall};
  endfunction

  // Drive one cycle, queue its expectation, check at the falling edge.
  task automatic step(input stim_t s, input outs_t e, input int tag);
    exp_t x;
    exp_t y;
    apply(s);
    x.o   = e;
    x.cnt = exp_cnt;
    x.to  = exp_to;
    x.tag = tag;
    sb.push_back(x);
    if (!e[4] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    @(negedge clk);
    y = sb.pop_front();
    cmp("outs", y.tag, 32'(dut_outs()), 32'(y.o));
    cmp("stall_cycles", y.tag, 32'(bus.stall_cycles), 32'(y.cnt));
    cmp("mem_timeout", y.tag, 32'(bus.mem_timeout), 32'(y.to));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n   = 1'b0;
    exp_cnt = 4'd0;
    exp_to  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    stim_t idle;
    total   = 0;
    bad     = 0;
    exp_cnt = 4'd0;
    exp_to  = 1'b0;
    idle    = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = '{mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), NRM};
    tbl[1]  = '{mk_s(3, 1, 1, 0, 3, 1, 1, 0, 0, 0, 0), LU};
    tbl[2]  = '{mk_s(3, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0), NRM};
    tbl[3]  = '{mk_s(2, 5, 0, 1, 5, 1, 1, 0, 0, 0, 0), LU};
    tbl[4]  = '{mk_s(2, 5, 0, 1, 5, 0, 1, 0, 0, 0, 0), NRM};
    tbl[5]  = '{mk_s(3, 1, 1, 0, 3, 1, 0, 0, 0, 0, 0), NRM};
    tbl[6]  = '{mk_s(2, 4, 1, 1, 3, 1, 1, 0, 0, 0, 0), NRM};
    tbl[7]  = '{mk_s(3, 3, 1, 1, 3, 1, 1, 1, 0, 0, 1), BR};
    tbl[8]  = '{mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), IM};
    tbl[9]  = '{mk_s(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 1), LU};
    tbl[10] = '{mk_s(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), NRM};
    tbl[11] = '{mk_s(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0), BR};
    tbl[12] = '{mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), NRM};
    tbl[13] = '{mk_s(0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0), BR};

    // Reset state: inputs look like a normal cycle, outputs must still be 0.
    rst_n = 1'b0;
    apply(idle);
    #7;
    cmp("rst_outs", 0, 32'(dut_outs()), 32'(0));
    cmp("rst_cnt", 0, 32'(bus.stall_cycles), 32'(0));
    cmp("rst_timeout", 0, 32'(bus.mem_timeout), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) step(tbl[i].s, tbl[i].e, i);

    // Load-use costs one cycle; the bubble in EX clears the hazard.
    step(mk_s(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0), LU, 100);
    step(mk_s(3, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0), NRM, 101);

    // dmem_Stall for 4 cycles with Done on the 4th: 3 lost cycles.
    do_reset();
    step(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), MW, 200);
    step(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), MW, 201);
    step(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), MW, 202);
    step(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), NRM, 203);
    cmp("mem_stall_cnt", 204, 32'(bus.stall_cycles), 32'(3));

    // Branch held during the wait is applied on the release cycle.
    step(mk_s(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), MW, 210);
    step(mk_s(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), MW, 211);
    step(mk_s(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0), BR, 212);
    step(idle, NRM, 213);

    // Timeout after 8 wait cycles, sticky past dmem_Done.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      exp_to = (k >= 9);
      step(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), MW, 300 + k);
    end
    exp_to = 1'b1;
    step(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), NRM, 320);
    step(idle, NRM, 321);

    // Asynchronous reset during the second wait cycle.
    step(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), MW, 400);
    step(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), MW, 401);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("midrst_outs", 402, 32'(dut_outs()), 32'(0));
    cmp("midrst_cnt", 402, 32'(bus.stall_cycles), 32'(0));
    cmp("midrst_timeout", 402, 32'(bus.mem_timeout), 32'(0));
    @(negedge clk);
    apply(idle);
    rst_n   = 1'b1;
    exp_cnt = 4'd0;
    exp_to  = 1'b0;
    @(posedge clk);
    #1;
    step(idle, NRM, 403);

    // Saturation of the 4-bit lost-cycle counter.
    for (int k = 0; k < 20; k++) step(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), IM, 500 + k);
    cmp("sat_cnt", 520, 32'(bus.stall_cycles), 32'(15));
    step(idle, NRM, 521);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
